// File: rtl/axis_fifo_drain.sv
// Read-side FIFO drain: pops a show-ahead FIFO into a registered AXI-stream master with TLAST framing.
// Optional packet counter (o_pktcount, i_pktcount_clr) is built when AXIS_FIFO_DRAIN_PKTCOUNT_EN is defined.
`timescale 1ns / 1ps

module axis_fifo_drain #(
    parameter int unsigned BW    = 8,
    parameter int unsigned LGPKT = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    output logic             o_rd,
    input  logic [BW-1:0]    i_data,
    input  logic             i_empty,
    input  logic [LGPKT-1:0] i_pktlen,
    output logic             M_AXIS_TVALID,
    input  logic             M_AXIS_TREADY,
    output logic [BW-1:0]    M_AXIS_TDATA,
    output logic             M_AXIS_TLAST,
`ifdef AXIS_FIFO_DRAIN_PKTCOUNT_EN
    input  logic             i_pktcount_clr,
    output logic [31:0]      o_pktcount,
`endif
    output logic             o_busy
);

    localparam int unsigned CW = LGPKT + 1;
    localparam logic [CW-1:0] MaxLen = {1'b1, {LGPKT{1'b0}}};
    localparam logic [CW-1:0] One    = CW'(1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e        state;
    logic [CW-1:0] remaining;
    logic [CW-1:0] start_len;

    // A zero length field encodes the maximum packet of 2^LGPKT beats.
    always_comb begin
        start_len = {1'b0, i_pktlen};
        if (i_pktlen == '0) begin
            start_len = MaxLen;
        end
    end

    // Pop whenever the output register is free or being drained this cycle.
    assign o_rd = !i_empty && (!M_AXIS_TVALID || M_AXIS_TREADY) && i_reset_n;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state         <= StIdle;
            remaining     <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (o_rd) begin
            M_AXIS_TDATA  <= i_data;
            M_AXIS_TVALID <= 1'b1;
            unique case (state)
                StIdle: begin
                    remaining <= start_len - One;
                    if (start_len == One) begin
                        M_AXIS_TLAST <= 1'b1;
                        state        <= StIdle;
                    end else begin
                        M_AXIS_TLAST <= 1'b0;
                        state        <= StActive;
                    end
                end
                StActive: begin
                    remaining <= remaining - One;
                    if (remaining == One) begin
                        M_AXIS_TLAST <= 1'b1;
                        state        <= StIdle;
                    end else begin
                        M_AXIS_TLAST <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end else if (M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
        end
    end

    assign o_busy = (state == StActive);

`ifdef AXIS_FIFO_DRAIN_PKTCOUNT_EN
    // Clear takes priority over a same-cycle completed packet.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_pktcount_clr) begin
            o_pktcount <= '0;
        end else if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
            o_pktcount <= o_pktcount + 32'd1;
        end
    end
`endif

endmodule
